hyperbus_arbiter: RTL and testbench
===================================

// Module: hyperbus_arbiter
// PURPOSE
//  Shares one hyperbus controller command port between NREQ requesters (e.g. hyperbus_fifo
//  instances, a DMA engine, a config master). Arbitrates rrq/wrq requests round-robin,
//  latches the winner's address/data/mask and issues one controller transaction at a time.
//  Routes hbus_valid back to the owner and pulses done when the controller returns idle.
// PARAMETERS
//  NREQ    2   number of requesters, 2..4
//  ADR_W   32  address width (matches hbus adr_i)
//  DAT_W   16  data word width (matches hbus dat_i/dat_o)
// PORTS
//  clk          in   1            system clock, same clock as the hyperbus controller
//  rst          in   1            asynchronous reset, active-high
//  req_rrq      in   NREQ         per-requester read request; level, held until ack
//  req_wrq      in   NREQ         per-requester write request; level, held until ack
//  req_adr_i    in   NREQ*ADR_W   flat addresses; requester i at [i*ADR_W +: ADR_W]
//  req_dat_i    in   NREQ*DAT_W   flat write data
//  req_mask_i   in   NREQ         per-requester write mask bit
//  req_ack_o    out  NREQ         one-cycle pulse: request accepted, inputs may change
//  req_valid_o  out  NREQ         read word valid for owner (mirrors hbus_valid)
//  req_done_o   out  NREQ         one-cycle pulse: owner's transaction complete
//  req_dat_o    out  DAT_W        read data, broadcast to all requesters
//  hbus_ready   in   1            controller idle / able to accept a command
//  hbus_valid   in   1            controller read word valid
//  hbus_dat_i   in   DAT_W        controller read data
//  hbus_rrq     out  1            read command pulse to controller
//  hbus_wrq     out  1            write command pulse to controller
//  hbus_adr_o   out  ADR_W        latched address of current transaction
//  hbus_dat_o   out  DAT_W        latched write data
//  hbus_mask_o  out  1            latched write mask
// BEHAVIOUR
//  Reset: state=IDLE, rr pointer=0, owner=0, all outputs 0 (hbus_adr_o/dat_o/mask_o = 0).
//  A requester is pending when req_rrq[i]|req_wrq[i]. Both set: write served; rrq stays pending.
//  FSM:
//   IDLE  : if hbus_ready && any pending -> pick winner (search starts at rr pointer),
//           latch adr/dat/mask and direction, owner<=winner, -> ISSUE. Otherwise stay.
//           hbus_ready low in IDLE: no issue, requests stay pending.
//   ISSUE : hbus_rrq or hbus_wrq =1 for exactly this cycle; req_ack_o[owner]=1 same cycle;
//           -> BUSY.
//   BUSY  : wait for hbus_ready=0 (controller accepted); -> DONE.
//   DONE  : wait for hbus_ready=1; then req_done_o[owner]=1 for one cycle,
//           rr pointer <= owner+1 (wraps modulo NREQ), -> IDLE.
//  Latency: pending at IDLE with hbus_ready=1 -> command on cycle+1; earliest next issue is
//   one cycle after done (back-to-back from different requesters, no idle gap beyond that).
//  req_valid_o[owner] = hbus_valid registered-through combinationally (same cycle), only
//   while state is BUSY or DONE; hbus_valid in IDLE/ISSUE is ignored. req_dat_o = hbus_dat_i.
//  hbus_adr_o/dat_o/mask_o hold latched values from ISSUE until next IDLE->ISSUE.
//  Requests deasserted before ack are simply not served; no state retained.
//  Reset mid-transaction: FSM to IDLE immediately, no done pulse; the controller is reset by
//   the same rst.
//  NREQ not a power of two: pointer wraps from NREQ-1 to 0.
// CONFIGURATION
//  HBUS_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins, rr pointer unused
//   (held at 0). Undefined (default): round-robin as above.
// TESTING
//  1 Reset asserted mid-DONE -> all outputs 0 next edge, state IDLE, no req_done_o pulse.
//  2 NREQ=2, req_wrq[0]=1 adr 0xAAAAAAAA dat 0xBEEF, hbus_ready=1 -> hbus_wrq pulse 1 cycle
//    later with hbus_adr_o=0xAAAAAAAA, hbus_dat_o=0xBEEF, req_ack_o=2'b01 same cycle.
//  3 req_rrq=2'b11 held continuously -> grants alternate 0,1,0,1; with
//    HBUS_ARB_FIXED_PRIO_EN -> requester 0 only, requester 1 starved.
//  4 Read by requester 1, model returns 2 words 0x1234,0x5678 -> req_valid_o=2'b10 twice,
//    req_dat_o matches, req_valid_o[0] never set, then req_done_o=2'b10 once.
//  5 hbus_ready held 0 with requests pending -> no hbus_rrq/wrq, no ack; raise ready ->
//    command issued next cycle.
//  6 Requester 0 sets wrq and rrq together -> write issued first, read issued on its next grant.

Source files
------------

// File: rtl/hyperbus_arbiter.sv
// Round-robin arbiter sharing one hyperbus controller command port among NREQ requesters.
// Define HBUS_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module hyperbus_arbiter #(
    parameter int NREQ  = 2,
    parameter int ADR_W = 32,
    parameter int DAT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_rrq,
    input  logic [NREQ-1:0]         req_wrq,
    input  logic [NREQ*ADR_W-1:0]   req_adr_i,
    input  logic [NREQ*DAT_W-1:0]   req_dat_i,
    input  logic [NREQ-1:0]         req_mask_i,
    output logic [NREQ-1:0]         req_ack_o,
    output logic [NREQ-1:0]         req_valid_o,
    output logic [NREQ-1:0]         req_done_o,
    output logic [DAT_W-1:0]        req_dat_o,
    input  logic                    hbus_ready,
    input  logic                    hbus_valid,
    input  logic [DAT_W-1:0]        hbus_dat_i,
    output logic                    hbus_rrq,
    output logic                    hbus_wrq,
    output logic [ADR_W-1:0]        hbus_adr_o,
    output logic [DAT_W-1:0]        hbus_dat_o,
    output logic                    hbus_mask_o
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY, S_DONE} state_t;

    state_t           state_q;
    logic [IDX_W-1:0] rr_q;
    logic [IDX_W-1:0] owner_q;
    logic [IDX_W-1:0] search_start;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_vld;
    logic [NREQ-1:0]  pending;

    function automatic logic [NREQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NREQ-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(NREQ - 1)) ? '0 : idx + IDX_W'(1);
    endfunction

`ifdef HBUS_ARB_FIXED_PRIO_EN
    assign search_start = '0;
`else
    assign search_start = rr_q;
`endif

    // First pending requester found walking upward from search_start, wrapping at NREQ-1.
    always_comb begin
        logic [IDX_W-1:0] idx;
        pending   = req_rrq | req_wrq;
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = search_start;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_vld && pending[idx]) begin
                grant_vld = 1'b1;
                grant_idx = idx;
            end
            idx = wrap_inc(idx);
        end
    end

    assign req_valid_o = (hbus_valid && (state_q == S_BUSY || state_q == S_DONE))
                         ? onehot(owner_q) : '0;
    assign req_dat_o   = hbus_dat_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rr_q        <= '0;
            owner_q     <= '0;
            req_ack_o   <= '0;
            req_done_o  <= '0;
            hbus_rrq    <= 1'b0;
            hbus_wrq    <= 1'b0;
            hbus_adr_o  <= '0;
            hbus_dat_o  <= '0;
            hbus_mask_o <= 1'b0;
        end else begin
            hbus_rrq   <= 1'b0;
            hbus_wrq   <= 1'b0;
            req_ack_o  <= '0;
            req_done_o <= '0;
            case (state_q)
                S_IDLE: begin
                    if (hbus_ready && grant_vld) begin
                        owner_q     <= grant_idx;
                        hbus_adr_o  <= req_adr_i[grant_idx*ADR_W +: ADR_W];
                        hbus_dat_o  <= req_dat_i[grant_idx*DAT_W +: DAT_W];
                        hbus_mask_o <= req_mask_i[grant_idx];
                        // Write wins when both are raised; the read stays pending.
                        hbus_wrq    <= req_wrq[grant_idx];
                        hbus_rrq    <= !req_wrq[grant_idx];
                        req_ack_o   <= onehot(grant_idx);
                        state_q     <= S_ISSUE;
                    end
                end
                S_ISSUE: state_q <= S_BUSY;
                S_BUSY: begin
                    if (!hbus_ready) state_q <= S_DONE;
                end
                S_DONE: begin
                    if (hbus_ready) begin
                        req_done_o <= onehot(owner_q);
`ifdef HBUS_ARB_FIXED_PRIO_EN
                        rr_q       <= '0;
`else
                        rr_q       <= wrap_inc(owner_q);
`endif
                        state_q    <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hyperbus_arbiter.sv
// Directed bench for hyperbus_arbiter with a command scoreboard and a scripted controller.
module tb_hyperbus_arbiter;
    localparam int NREQ  = 2;
    localparam int ADR_W = 32;
    localparam int DAT_W = 16;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req_rrq = '0;
    logic [NREQ-1:0]       req_wrq = '0;
    logic [NREQ*ADR_W-1:0] req_adr_i = '0;
    logic [NREQ*DAT_W-1:0] req_dat_i = '0;
    logic [NREQ-1:0]       req_mask_i = '0;
    logic [NREQ-1:0]       req_ack_o;
    logic [NREQ-1:0]       req_valid_o;
    logic [NREQ-1:0]       req_done_o;
    logic [DAT_W-1:0]      req_dat_o;
    logic                  hbus_ready = 1'b1;
    logic                  hbus_valid = 1'b0;
    logic [DAT_W-1:0]      hbus_dat_i = '0;
    logic                  hbus_rrq;
    logic                  hbus_wrq;
    logic [ADR_W-1:0]      hbus_adr_o;
    logic [DAT_W-1:0]      hbus_dat_o;
    logic                  hbus_mask_o;

    always #5 clk = ~clk;

    hyperbus_arbiter #(.NREQ(NREQ), .ADR_W(ADR_W), .DAT_W(DAT_W)) dut (
        .clk(clk), .rst(rst),
        .req_rrq(req_rrq), .req_wrq(req_wrq), .req_adr_i(req_adr_i),
        .req_dat_i(req_dat_i), .req_mask_i(req_mask_i),
        .req_ack_o(req_ack_o), .req_valid_o(req_valid_o), .req_done_o(req_done_o),
        .req_dat_o(req_dat_o),
        .hbus_ready(hbus_ready), .hbus_valid(hbus_valid), .hbus_dat_i(hbus_dat_i),
        .hbus_rrq(hbus_rrq), .hbus_wrq(hbus_wrq), .hbus_adr_o(hbus_adr_o),
        .hbus_dat_o(hbus_dat_o), .hbus_mask_o(hbus_mask_o)
    );

    typedef struct packed {
        logic             wr;
        logic [NREQ-1:0]  ack;
        logic [ADR_W-1:0] adr;
        logic [DAT_W-1:0] dat;
        logic             mask;
    } cmd_t;

    cmd_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int r, input logic wr);
        cmd_t e;
        e.wr   = wr;
        e.ack  = NREQ'(1) << r;
        e.adr  = req_adr_i[r*ADR_W +: ADR_W];
        e.dat  = req_dat_i[r*DAT_W +: DAT_W];
        e.mask = req_mask_i[r];
        exp_q.push_back(e);
    endtask

    // Waits for a command, scores it, then plays the controller: accept, return words, go idle.
    task automatic do_txn(input logic [NREQ-1:0] rrq_after, input logic [NREQ-1:0] wrq_after,
                          input int nwords, input logic [DAT_W-1:0] w0, input logic [DAT_W-1:0] w1);
        int               n;
        cmd_t             e;
        logic [DAT_W-1:0] words [2];
        words[0] = w0;
        words[1] = w1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(hbus_rrq | hbus_wrq) && n < 20);
        chk("cmd_latency", 64'(n), 64'd1);
        if (!(hbus_rrq | hbus_wrq)) return;
        if (exp_q.size() == 0) begin
            chk("unexpected_cmd", 64'd1, 64'd0);
            return;
        end
        e = exp_q.pop_front();
        chk("cmd_wrq", 64'(hbus_wrq), 64'(e.wr));
        chk("cmd_rrq", 64'(hbus_rrq), 64'(!e.wr));
        chk("ack", 64'(req_ack_o), 64'(e.ack));
        chk("adr", 64'(hbus_adr_o), 64'(e.adr));
        chk("wdat", 64'(hbus_dat_o), 64'(e.dat));
        chk("mask", 64'(hbus_mask_o), 64'(e.mask));
        chk("done_low_at_issue", 64'(req_done_o), 64'd0);
        req_rrq    = rrq_after;
        req_wrq    = wrq_after;
        hbus_valid = 1'b1;
        hbus_dat_i = 16'hDEAD;
        #1;
        chk("valid_ignored_issue", 64'(req_valid_o), 64'd0);
        hbus_valid = 1'b0;
        hbus_ready = 1'b0;
        @(negedge clk);
        chk("cmd_one_cycle", 64'(hbus_rrq | hbus_wrq), 64'd0);
        @(negedge clk);
        for (int i = 0; i < nwords; i++) begin
            hbus_valid = 1'b1;
            hbus_dat_i = words[i];
            #1;
            chk("rd_valid", 64'(req_valid_o), 64'(e.ack));
            chk("rd_dat", 64'(req_dat_o), 64'(words[i]));
            @(negedge clk);
        end
        hbus_valid = 1'b0;
        hbus_ready = 1'b1;
        @(negedge clk);
        chk("done", 64'(req_done_o), 64'(e.ack));
    endtask

    initial begin
        req_adr_i = {32'h1111_0001, 32'h0000_0000};
        req_dat_i = {16'h0011, 16'h0000};
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rrq", 64'(hbus_rrq), 64'd0);
        chk("rst_wrq", 64'(hbus_wrq), 64'd0);
        chk("rst_adr", 64'(hbus_adr_o), 64'd0);
        chk("rst_dat", 64'(hbus_dat_o), 64'd0);
        chk("rst_mask", 64'(hbus_mask_o), 64'd0);
        chk("rst_ack", 64'(req_ack_o), 64'd0);
        chk("rst_done", 64'(req_done_o), 64'd0);

        // Single write from requester 0.
        req_adr_i[31:0] = 32'hAAAA_AAAA;
        req_dat_i[15:0] = 16'hBEEF;
        req_mask_i      = 2'b01;
        req_wrq         = 2'b01;
        push(0, 1'b1);
        do_txn(2'b00, 2'b00, 0, '0, '0);

        // Two-word read by requester 1.
        req_adr_i[63:32] = 32'h0000_0100;
        req_dat_i[31:16] = 16'h0F0F;
        req_mask_i       = 2'b00;
        req_rrq          = 2'b10;
        push(1, 1'b0);
        do_txn(2'b00, 2'b00, 2, 16'h1234, 16'h5678);

        // Both read requests held continuously.
        req_adr_i = {32'h2222_0002, 32'h3333_0003};
        req_rrq   = 2'b11;
`ifdef HBUS_ARB_FIXED_PRIO_EN
        push(0, 1'b0); push(0, 1'b0); push(0, 1'b0); push(0, 1'b0);
`else
        push(0, 1'b0); push(1, 1'b0); push(0, 1'b0); push(1, 1'b0);
`endif
        do_txn(2'b11, 2'b00, 0, '0, '0);
        do_txn(2'b11, 2'b00, 0, '0, '0);
        do_txn(2'b11, 2'b00, 0, '0, '0);
        do_txn(2'b00, 2'b00, 0, '0, '0);

        // Write and read raised together by requester 0.
        req_adr_i[31:0] = 32'h4444_0004;
        req_dat_i[15:0] = 16'hCAFE;
        req_mask_i      = 2'b01;
        req_rrq         = 2'b01;
        req_wrq         = 2'b01;
        push(0, 1'b1);
        push(0, 1'b0);
        do_txn(2'b01, 2'b00, 0, '0, '0);
        do_txn(2'b00, 2'b00, 1, 16'h9ABC, '0);

        // Controller not ready: nothing issues until ready rises.
        hbus_ready      = 1'b0;
        req_adr_i[31:0] = 32'h5555_0005;
        req_rrq         = 2'b01;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("notready_cmd", 64'(hbus_rrq | hbus_wrq), 64'd0);
            chk("notready_ack", 64'(req_ack_o), 64'd0);
        end
        push(0, 1'b0);
        hbus_ready = 1'b1;
        do_txn(2'b00, 2'b00, 0, '0, '0);

        // Reset while in DONE.
        req_rrq = 2'b10;
        @(negedge clk);
        chk("pre_rst_cmd", 64'(hbus_rrq), 64'd1);
        req_rrq    = 2'b00;
        hbus_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst        = 1'b1;
        hbus_ready = 1'b1;
        hbus_valid = 1'b1;
        #1;
        chk("midrst_adr", 64'(hbus_adr_o), 64'd0);
        chk("midrst_dat", 64'(hbus_dat_o), 64'd0);
        chk("midrst_mask", 64'(hbus_mask_o), 64'd0);
        chk("midrst_valid", 64'(req_valid_o), 64'd0);
        chk("midrst_cmd", 64'(hbus_rrq | hbus_wrq), 64'd0);
        hbus_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst_no_done", 64'(req_done_o), 64'd0);
        end

        // Arbiter still serves normally after the reset.
        req_dat_i[31:16] = 16'h7777;
        req_mask_i       = 2'b10;
        req_wrq          = 2'b10;
        push(1, 1'b1);
        do_txn(2'b00, 2'b00, 0, '0, '0);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
